// File: rtl/gate_stim_check.sv
// -----------------------------------------------------------------------------
// gate_stim_check
//   Drives the four input combinations (00, 01, 10, 11) of a 2-input gate under
//   test onto A/B, holds each for DWELL cycles, samples the gate output Y
//   SETTLE cycles after each vector is applied, and counts mismatches against
//   the truth table of the selected gate.
//
// Parameters
//   DWELL    cycles each vector is held (>= 2)
//   SETTLE   cycles after vector application at which Y is sampled
//            (1 <= SETTLE <= DWELL-1)
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request one test run (IDLE/DONE only, legal op_sel only)
//   op_sel   gate under test: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR
//   A, B     stimulus to the gate inputs
//   Y        gate output under test
//   busy     run in progress
//   done     run complete (held until restart or reset)
//   pass     valid with done; 1 when no vector mismatched
//   err_cnt  mismatching vectors in the current/last run (0-4)
//   vec_idx  index of the vector currently driven
// -----------------------------------------------------------------------------
module gate_stim_check #(
    parameter int DWELL  = 100,
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] op_sel,
    output logic       A,
    output logic       B,
    input  logic       Y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [1:0] vec_idx
);

    localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DCW-1:0] SETTLE_C = DCW'(SETTLE);
    localparam logic [DCW-1:0] LAST_C   = DCW'(DWELL - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [1:0]       vec_q, vec_d;
    logic [DCW-1:0]   dwell_q, dwell_d;
    logic [2:0]       err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             exp_y;

    // Expected gate output for the latched op and the vector on A/B now.
    always_comb begin
        exp_y = 1'b0;
        unique case (op_q)
            3'd0:    exp_y =   a_q & b_q;
            3'd1:    exp_y =   a_q | b_q;
            3'd2:    exp_y = ~(a_q & b_q);
            3'd3:    exp_y = ~(a_q | b_q);
            3'd4:    exp_y =   a_q ^ b_q;
            3'd5:    exp_y = ~(a_q ^ b_q);
            default: exp_y = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        vec_d   = vec_q;
        dwell_d = dwell_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        a_d     = a_q;
        b_d     = b_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start && (op_sel <= 3'd5)) begin
                    state_d = ST_DRIVE;
                    op_d    = op_sel;
                    vec_d   = 2'd0;
                    dwell_d = '0;
                    err_d   = 3'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                end
            end

            ST_DRIVE: begin
                // One compare per vector: dwell_q only equals SETTLE once per vector.
                if ((dwell_q == SETTLE_C) && (Y != exp_y)) begin
                    err_d = err_q + 3'd1;
                end

                if (dwell_q == LAST_C) begin
                    dwell_d = '0;
                    if (vec_q == 2'd3) begin
                        // err_d already includes a vector-3 compare landing on this edge.
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == 3'd0);
                        vec_d   = 2'd0;
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                    end else begin
                        vec_d = vec_q + 2'd1;
                        a_d   = vec_d[1];
                        b_d   = vec_d[0];
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                a_d     = 1'b0;
                b_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= 3'd0;
            vec_q   <= 2'd0;
            dwell_q <= '0;
            err_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            vec_q   <= vec_d;
            dwell_q <= dwell_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign A       = a_q;
    assign B       = b_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign err_cnt = err_q;
    assign vec_idx = vec_q;

endmodule

// File: tb/tb_gate_stim_check.sv
module tb_gate_stim_check;

    // Truth tables indexed by {A,B}: bit 3 is A=1,B=1.
    localparam logic [3:0] TT [6] = '{4'b1000, 4'b1110, 4'b0111,
                                      4'b0001, 4'b0110, 4'b1001};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [2:0] op_sel = 3'd0;
    logic       a0, b0, y0, busy0, done0, pass0;
    logic       a1, b1, y1, busy1, done1, pass1;
    logic [2:0] err0, err1;
    logic [1:0] vec0, vec1;

    int  y_op    = 0;
    bit  y_trick = 1'b0;   // when set, Y is wrong on every cycle except the sampling cycle
    int  phase   = 0;      // cycles since the current vector was applied
    int  n_chk   = 0;
    int  n_pass  = 0;

    always #5 clk = ~clk;

    assign y0 = TT[y_op][{a0, b0}] ^ (y_trick && (phase != 1));
    assign y1 = TT[y_op][{a1, b1}] ^ (y_trick && (phase != 2));

    gate_stim_check #(.DWELL(4), .SETTLE(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .op_sel(op_sel),
        .A(a0), .B(b0), .Y(y0), .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(err0), .vec_idx(vec0)
    );

    gate_stim_check #(.DWELL(100), .SETTLE(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op_sel(op_sel),
        .A(a1), .B(b1), .Y(y1), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .vec_idx(vec1)
    );

    // {busy, done, pass, err_cnt, vec_idx, A, B}
    function automatic logic [9:0] obs(input int sel);
        return sel ? {busy1, done1, pass1, err1, vec1, a1, b1}
                   : {busy0, done0, pass0, err0, vec0, a0, b0};
    endfunction

    task automatic chk(input string tag, input logic [9:0] o, input logic [9:0] e);
        n_chk++;
        assert (o === e) n_pass++;
        else $error("FAIL %s observed=%b expected=%b (busy,done,pass,err,vec,A,B)", tag, o, e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel) start1 = v; else start0 = v;
    endtask

    // One full run: accept at edge T, check every cycle until done at T+4*DWELL.
    task automatic run(input int sel, input int op, input int yop, input bit trick,
                       input bit inj_mid, input bit inj_end, input string tag);
        int d;
        int exp_err;
        int v;
        logic [1:0] vv;
        logic [9:0] fin;
        d = sel ? 100 : 4;
        exp_err = 0;
        for (int i = 0; i < 4; i++)
            if (TT[op][i] != TT[yop][i]) exp_err++;
        op_sel  = op[2:0];
        y_op    = yop;
        y_trick = trick;
        set_start(sel, 1'b1);
        step();
        set_start(sel, 1'b0);
        phase = 0;
        chk({tag, "_accept"}, obs(sel), 10'b1_0_0_000_00_0_0);
        for (int k = 1; k <= 4 * d; k++) begin
            if ((inj_mid && k == d + 1) || (inj_end && k == 4 * d)) begin
                set_start(sel, 1'b1);
                op_sel = 3'd1;
            end
            step();
            set_start(sel, 1'b0);
            phase = k % d;
            if (k < 4 * d) begin
                v  = k / d;
                vv = v[1:0];
                chk({tag, "_drive"}, {obs(sel)[9:8], obs(sel)[3:0]},
                    {1'b1, 1'b0, vv, vv[1], vv[0]});
            end
        end
        fin = {1'b0, 1'b1, (exp_err == 0), 3'(exp_err), 2'd0, 1'b0, 1'b0};
        chk({tag, "_done"}, obs(sel), fin);
        if (inj_end) begin
            step();
            chk({tag, "_end_start_ignored"}, obs(sel), fin);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset
        rst_n = 1'b0;
        #2;
        chk("por_dut0", obs(0), 10'd0);
        chk("por_dut1", obs(1), 10'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Illegal op codes from IDLE are ignored
        op_sel = 3'd6; start0 = 1'b1; step(); start0 = 1'b0;
        chk("op6_idle", obs(0), 10'd0);
        op_sel = 3'd7; start0 = 1'b1; step(); start0 = 1'b0;
        chk("op7_idle", obs(0), 10'd0);

        // AND vs ideal AND; OR start injected during vector 1
        run(0, 0, 0, 1'b0, 1'b1, 1'b0, "and_pass");
        // XOR against an AND gate: 3 mismatches; start at DONE entry ignored
        run(0, 4, 0, 1'b0, 1'b0, 1'b1, "xor_vs_and");
        op_sel = 3'd6; start0 = 1'b1; step(); start0 = 1'b0;
        chk("op6_done", obs(0), 10'b0_1_0_011_00_0_0);
        // Restart from DONE with a correct XOR gate, Y only valid at the sample point
        run(0, 4, 4, 1'b1, 1'b0, 1'b0, "xor_restart");

        // Asynchronous reset mid-run while vector 2 is driven
        op_sel = 3'd0; y_op = 0; y_trick = 1'b0;
        start0 = 1'b1; step(); start0 = 1'b0;
        repeat (9) step();
        chk("pre_abort", {obs(0)[9:8], obs(0)[3:0]}, 6'b10_10_1_0);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_dut0", obs(0), 10'd0);
        chk("abort_dut1", obs(1), 10'd0);
        #2 rst_n = 1'b1;
        // Start present at the first edge after release
        run(0, 5, 5, 1'b0, 1'b0, 1'b0, "xnor_after_reset");

        // Randomized runs against the truth-table model
        for (int r = 0; r < 8; r++) begin
            run(0, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), "rand");
        end

        // Default-size instance: done at T+400
        run(1, 0, 0, 1'b1, 1'b0, 1'b0, "big_and_pass");
        run(1, 2, 3, 1'b1, 1'b1, 1'b1, "big_nand_vs_nor");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gate_stim_check.md
GATE_STIM_CHECK -- requirements
Module: gate_stim_check

Interface
REQ-001 Parameter DWELL, default 100, clock cycles each input vector is held on A/B.
REQ-002 Parameter SETTLE, default 2, cycles after vector application at which Y is sampled; legal range 1 <= SETTLE <= DWELL-1.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to run one test sequence; sampled each rising edge.
REQ-006 op_sel  input  3  gate under test: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR; 6-7 invalid.
REQ-007 A  output  1  stimulus to gate input A.
REQ-008 B  output  1  stimulus to gate input B.
REQ-009 Y  input  1  gate output under test.
REQ-010 busy  output  1  high while the sequence is running.
REQ-011 done  output  1  high when the sequence has completed; held until restart or reset.
REQ-012 pass  output  1  valid when done=1; 1 when no mismatch occurred.
REQ-013 err_cnt  output  3  number of mismatching vectors in the current or last run, 0-4.
REQ-014 vec_idx  output  2  index of the vector currently driven.

Function
REQ-015 States: IDLE, DRIVE, DONE; all outputs registered.
REQ-016 IDLE or DONE, start=1, op_sel<=5 -> latch op_sel, clear done/pass/err_cnt, vec_idx=0, dwell_cnt=0, enter DRIVE, busy=1, all at the same edge.
REQ-017 start with op_sel 6 or 7 is ignored; state and outputs unchanged.
REQ-018 start while in DRIVE is ignored; latched op_sel is not changed mid-run.
REQ-019 In DRIVE: A = vec_idx[1], B = vec_idx[0], so the order is 00, 01, 10, 11.
REQ-020 In DRIVE: dwell_cnt increments by 1 each cycle, 0 to DWELL-1, then wraps to 0 while vec_idx increments.
REQ-021 Sampling: at the edge where dwell_cnt == SETTLE, compare Y with the expected truth-table value for the latched op and current A/B.
REQ-022 A mismatch increments err_cnt by 1; at most one compare per vector.
REQ-023 After the last cycle of vector 3 (vec_idx=3, dwell_cnt=DWELL-1), enter DONE.
REQ-024 On entering DONE: busy=0, done=1, pass=(err_cnt==0 including the vector-3 result), A=B=0, vec_idx=0.
REQ-025 Latency: start accepted at edge T -> done rises at edge T+4*DWELL; exactly DWELL cycles per vector.
REQ-026 While in IDLE and DONE: A=B=0.
REQ-027 Simultaneous start and DONE entry: start is ignored because the FSM was in DRIVE at that edge.
REQ-028 Restart from DONE: done and pass clear at the accepting edge; the new run is identical to a run started from IDLE.

Reset
REQ-029 rst_n=0 -> immediately, without waiting for clk: state=IDLE, A=0, B=0, busy=0, done=0, pass=0, err_cnt=0, vec_idx=0, dwell_cnt=0, latched op=0.
REQ-030 Reset mid-run aborts the sequence with no partial done/pass; the first start after release runs from vector 0.
REQ-031 The first rising edge after rst_n deasserts behaves as a normal IDLE cycle; a start present at that edge is accepted.

Verification (DWELL=4, SETTLE=1 unless noted)
REQ-032 Reset: assert rst_n=0 between clock edges -> all outputs 0 at once, before the next edge.
REQ-033 op_sel=0, Y from an ideal AND model, start pulse at edge T -> A/B = 00,01,10,11 for 4 cycles each; done=1 at T+16; pass=1; err_cnt=0.
REQ-034 op_sel=4 (XOR), Y from an AND model -> mismatches at 01, 10, 11; err_cnt=3; pass=0; done=1 at T+16.
REQ-035 start with op_sel=6 in IDLE -> busy stays 0. Also: start with op_sel=1 during vector 1 of a running op_sel=0 sequence -> ignored, run completes as AND.
REQ-036 rst_n pulse while vec_idx=2 -> outputs to reset values. Then start with op_sel=5 and a matching XNOR model -> full 16-cycle run, pass=1.
REQ-037 After a failing run (err_cnt=3), restart from DONE with correct Y -> done=0 and err_cnt=0 at the accepting edge; final pass=1. Repeat the pass case with DWELL=100, SETTLE=2 -> done at T+400.
